// File: rtl/ppc_fetch_queue.sv
// ppc_fetch_queue
// ---------------------------------------------------------------------------
// Instruction fetch stage in front of the single-cycle PowerPC execute core.
// Holds the fetch PC, reads one 64-bit doubleword per cycle from the
// instruction port, splits it into two big-endian 32-bit words and buffers
// them with their PCs in a DEPTH-entry FIFO. The head is offered to the core
// with a valid/ready handshake. A redirect flushes the queue and restarts
// fetch at the new PC.
//
// Optional build macro: FETCH_BRANCH_FOLD_EN
//   When defined, each enqueued word is predecoded. An unconditional
//   I-form branch (opcode 18) is marked pred_taken, the rest of its
//   doubleword is discarded, and fetch continues at the branch target.
//   When undefined, fetch is purely sequential and inst_pred_taken is 0.
//
// Ports (big-endian bit numbering, bit 0 is the MSB):
//   clk             clock, all state updates on posedge
//   rst             synchronous active-high reset
//   mem_addr        [0:60] doubleword read address (fetch_pc[0:60])
//   mem_data        [0:63] read data, combinational from mem_addr
//   redirect_valid  core requests a PC change this cycle
//   redirect_pc     [0:63] new fetch PC, bits [62:63] ignored
//   inst_valid      queue head holds a valid instruction
//   inst            [0:31] head instruction (0 when not valid)
//   inst_pc         [0:63] head instruction address (0 when not valid)
//   inst_pred_taken head was followed by the fetcher as a taken branch
//   inst_ready      core consumes the head this cycle
// ---------------------------------------------------------------------------
module ppc_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [0:63] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [0:60]  mem_addr,
  input  logic [0:63]  mem_data,
  input  logic         redirect_valid,
  input  logic [0:63]  redirect_pc,
  output logic         inst_valid,
  output logic [0:31]  inst,
  output logic [0:63]  inst_pc,
  output logic         inst_pred_taken,
  input  logic         inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [0:63] RESET_PC_W = {RESET_PC[0:61], 2'b00};

  logic [0:63]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [0:31]   inst_mem_q [DEPTH];
  logic [0:31]   inst_mem_d [DEPTH];
  logic [0:63]   pc_mem_q   [DEPTH];
  logic [0:63]   pc_mem_d   [DEPTH];
`ifdef FETCH_BRANCH_FOLD_EN
  logic          pt_mem_q   [DEPTH];
  logic          pt_mem_d   [DEPTH];
`endif

  logic [CW-1:0] free;
  logic [0:31]   w0, w1;
  logic [0:63]   pc0, pc1;
  logic          push0, push1, pop;
  logic [1:0]    n_push;
  logic [PW-1:0] slot1;
  logic          br0, br1;
  logic [0:63]   tgt0, tgt1;
  logic [0:63]   dword_next, word_next;
  logic          unused_redirect_low;

  // Low two redirect bits are forced to zero by the word alignment.
  assign unused_redirect_low = ^redirect_pc[62:63];

  assign mem_addr = fetch_pc_q[0:60];

  // Credit is taken from the count at the start of the cycle only; a pop in
  // the same cycle does not make room for this cycle's push.
  assign free = CW'(DEPTH) - count_q;

  assign w0  = mem_data[0:31];
  assign w1  = mem_data[32:63];
  assign pc0 = {fetch_pc_q[0:60], 3'b000};
  assign pc1 = {fetch_pc_q[0:60], 3'b100};

  // Both PC increments wrap modulo 2^64.
  assign dword_next = {fetch_pc_q[0:60], 3'b000} + 64'd8;
  assign word_next  = fetch_pc_q + 64'd4;

`ifdef FETCH_BRANCH_FOLD_EN
  // Target of an I-form branch: LI||00 sign-extended, absolute when AA=1.
  function automatic logic [0:63] branch_target(input logic [0:23] li,
                                                input logic aa,
                                                input logic [0:63] pc);
    logic [0:63] disp;
    disp = {{38{li[0]}}, li, 2'b00};
    return aa ? disp : pc + disp;
  endfunction

  assign br0  = (w0[0:5] == 6'd18);
  assign br1  = (w1[0:5] == 6'd18);
  assign tgt0 = branch_target(w0[6:29], w0[30], pc0);
  assign tgt1 = branch_target(w1[6:29], w1[30], pc1);
`else
  assign br0  = 1'b0;
  assign br1  = 1'b0;
  assign tgt0 = '0;
  assign tgt1 = '0;
`endif

  // The low word is only fetched from an even-word PC. The high word needs
  // two free slots if the low word is going in too, and is dropped when a
  // folded branch in the low word already steers fetch elsewhere.
  assign push0 = !fetch_pc_q[61] && (free >= CW'(1));
  assign push1 = fetch_pc_q[61] ? (free >= CW'(1))
                                : ((free >= CW'(2)) && !br0);

  assign n_push = {1'b0, push0} + {1'b0, push1};
  assign slot1  = push0 ? tail_q + PW'(1) : tail_q;
  assign pop    = inst_valid && inst_ready;

  // Next-state logic: a redirect flushes everything and swallows any pop or
  // push of this cycle; otherwise push up to two words and pop the head.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      inst_mem_d[i] = inst_mem_q[i];
      pc_mem_d[i]   = pc_mem_q[i];
`ifdef FETCH_BRANCH_FOLD_EN
      pt_mem_d[i]   = pt_mem_q[i];
`endif
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[0:61], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push0) begin
        inst_mem_d[tail_q] = w0;
        pc_mem_d[tail_q]   = pc0;
`ifdef FETCH_BRANCH_FOLD_EN
        pt_mem_d[tail_q]   = br0;
`endif
      end
      if (push1) begin
        inst_mem_d[slot1] = w1;
        pc_mem_d[slot1]   = pc1;
`ifdef FETCH_BRANCH_FOLD_EN
        pt_mem_d[slot1]   = br1;
`endif
      end

      tail_d  = tail_q + PW'(n_push);
      head_d  = pop ? head_q + PW'(1) : head_q;
      count_d = count_q + CW'(n_push) - CW'(pop);

      if (push0 && br0) begin
        fetch_pc_d = tgt0;
      end else if (push1 && br1) begin
        fetch_pc_d = tgt1;
      end else if (push1) begin
        fetch_pc_d = dword_next;
      end else if (push0) begin
        fetch_pc_d = word_next;
      end
    end
  end

  // State registers; reset has priority over redirect and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_W;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
`ifdef FETCH_BRANCH_FOLD_EN
        pt_mem_q[i]   <= 1'b0;
`endif
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= inst_mem_d[i];
        pc_mem_q[i]   <= pc_mem_d[i];
`ifdef FETCH_BRANCH_FOLD_EN
        pt_mem_q[i]   <= pt_mem_d[i];
`endif
      end
    end
  end

  // Head outputs read straight from storage, masked to zero when empty.
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? inst_mem_q[head_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[head_q]   : '0;
`ifdef FETCH_BRANCH_FOLD_EN
  assign inst_pred_taken = inst_valid && pt_mem_q[head_q];
`else
  assign inst_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Directed testbench for ppc_fetch_queue (DEPTH=4, RESET_PC=0).
// The memory model returns, for every word not given a special value,
// 0xA0000000 | (pc & 0x1FF), so each word identifies its own address.
module tb_ppc_fetch_queue;

  logic         clk;
  logic         rst;
  logic [0:60]  mem_addr;
  logic [0:63]  mem_data;
  logic         redirect_valid;
  logic [0:63]  redirect_pc;
  logic         inst_valid;
  logic [0:31]  inst;
  logic [0:63]  inst_pc;
  logic         inst_pred_taken;
  logic         inst_ready;

  int total;
  int bad;

`ifdef FETCH_BRANCH_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  ppc_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pred_taken (inst_pred_taken),
    .inst_ready      (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected instruction word at a given PC (memory aliases every 0x200).
  function automatic logic [31:0] wordAt(input logic [63:0] p);
    logic [8:0] a;
    a = p[8:0];
    case (a)
      9'h000:  return 32'h3860_0041;
      9'h004:  return 32'h3800_0000;
      9'h100:  return 32'h4800_0040;
      default: return 32'hA000_0000 | {23'd0, a};
    endcase
  endfunction

  // Combinational instruction memory, 64 doublewords.
  logic [63:0] mem_dw [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_dw[i] = {wordAt(64'(i * 8)), wordAt(64'(i * 8 + 4))};
    end
  end
  assign mem_data = mem_dw[mem_addr[55:60]];

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive inputs for the current cycle, then advance one clock edge.
  task automatic applyStimulus(input logic r, input logic rv,
                               input logic [63:0] rpc, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expectHead(input string tag, input logic [63:0] pc,
                            input logic pt);
    checkOutput({tag, ".valid"}, {63'd0, inst_valid}, 64'd1);
    checkOutput({tag, ".pc"}, inst_pc, pc);
    checkOutput({tag, ".inst"}, {32'd0, inst}, {32'd0, wordAt(pc)});
    checkOutput({tag, ".pt"}, {63'd0, inst_pred_taken}, {63'd0, pt});
  endtask

  task automatic expectEmpty(input string tag);
    checkOutput({tag, ".valid"}, {63'd0, inst_valid}, 64'd0);
    checkOutput({tag, ".pc"}, inst_pc, 64'd0);
    checkOutput({tag, ".inst"}, {32'd0, inst}, 64'd0);
    checkOutput({tag, ".pt"}, {63'd0, inst_pred_taken}, 64'd0);
  endtask

  // Watchdog: the directed sequence is fixed-length, this only guards hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] seq[$];
    total = 0;
    bad   = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset then stream from PC 0 with the core always ready.
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    expectEmpty("rst");
    checkOutput("rst.maddr", {3'b0, mem_addr}, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t1.c1", 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t1.c2", 64'h4, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t1.c3", 64'h8, 1'b0);

    // Back-pressure from reset fills the queue, then drain in order.
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t2.maddr", {3'b0, mem_addr}, 64'h2);
    seq = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h14};
    foreach (seq[k]) begin
      expectHead($sformatf("t2.s%0d", k), seq[k], 1'b0);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    end

    // Redirect into the high word of a doubleword.
    applyStimulus(1'b0, 1'b1, 64'hC, 1'b1);
    expectEmpty("t3.r1");
    checkOutput("t3.maddr", {3'b0, mem_addr}, 64'h1);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    seq = '{64'hC, 64'h10, 64'h14};
    foreach (seq[k]) begin
      expectHead($sformatf("t3.s%0d", k), seq[k], 1'b0);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    end

    // Full queue plus redirect with a same-cycle pop; low PC bits ignored.
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    expectHead("t4.full", 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h23, 1'b1);
    expectEmpty("t4.r1");
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t4.r2", 64'h20, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t4.r3", 64'h24, 1'b0);

    // One free slot at an even PC: only the low word goes in.
    applyStimulus(1'b0, 1'b1, 64'h34, 1'b0);
    expectEmpty("t5.r1");
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t5.maddr", {3'b0, mem_addr}, 64'h8);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    seq = '{64'h34, 64'h38, 64'h3C, 64'h40, 64'h44, 64'h48};
    foreach (seq[k]) begin
      expectHead($sformatf("t5.s%0d", k), seq[k], 1'b0);
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    end

    // Branch at 0x100: folded when the feature is built in.
    applyStimulus(1'b0, 1'b1, 64'h100, 1'b1);
    expectEmpty("t6.r1");
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t6.br", 64'h100, FOLD);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t6.n1", FOLD ? 64'h140 : 64'h104, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t6.n2", FOLD ? 64'h144 : 64'h108, 1'b0);

    // PC wrap from the top of the address space.
    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    expectEmpty("t7.r1");
    checkOutput("t7.maddr", {3'b0, mem_addr}, 64'h1FFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t7.top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t7.w0", 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t7.w1", 64'h4, 1'b0);

    // Reset wins over a simultaneous redirect.
    applyStimulus(1'b1, 1'b1, 64'h100, 1'b1);
    expectEmpty("t8.rst");
    checkOutput("t8.maddr", {3'b0, mem_addr}, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    expectHead("t8.c1", 64'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
